// File: rtl/glitch_cmd_master.sv
// Host-side command initiator for the fault-injector byte protocol: serialises one
// request onto a UART transmitter and assembles the injector's reply into a response word.
module glitch_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd,
  input  logic [31:0] req_value,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_error,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        rx_done,
  input  logic [7:0]  rx_data
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT_TX, S_RECV, S_DONE} state_e;
  typedef enum logic [2:0] {C_SET, C_GET, C_PING, C_ARMST, C_PLAIN, C_BAD} cls_e;

  state_e          state_q, state_d;
  cls_e            cls_q, cls_d, req_cls;
  logic [39:0]     tx_sh_q, tx_sh_d;
  logic [2:0]      tx_cnt_q, tx_cnt_d;
  logic [2:0]      rx_cnt_q, rx_cnt_d;
  logic [31:0]     rx_buf_q, rx_buf_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            first_q, first_d;
  logic            rx_en_q, rx_en_d;
  logic            tmo_q, tmo_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic            rsp_error_q, rsp_error_d;
  logic            tx_start_c;
  logic            rx_capture;

  always_comb begin
    case (req_cmd)
      8'hA0, 8'hA1, 8'hA2: req_cls = C_SET;
      8'hB0, 8'hB1, 8'hB2: req_cls = C_GET;
      8'hC0:               req_cls = C_PING;
      8'h03:               req_cls = C_ARMST;
      8'h01, 8'h02, 8'h04: req_cls = C_PLAIN;
      default:             req_cls = C_BAD;
    endcase
  end

  // Capture opens with the command byte so a fast responder can reply during WAIT_TX.
  assign rx_capture = rx_done && rx_en_q && (rx_cnt_q != 3'd0);

  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    tx_sh_d     = tx_sh_q;
    tx_cnt_d    = tx_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    rx_buf_d    = rx_buf_q;
    to_cnt_d    = '0;
    first_d     = first_q;
    rx_en_d     = rx_en_q;
    tmo_d       = tmo_q;
    tx_data_d   = tx_data_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;
    tx_start_c  = 1'b0;

    if (rx_capture) begin
      case (rx_cnt_q)
        3'd4:    rx_buf_d[31:24] = rx_data;
        3'd3:    rx_buf_d[23:16] = rx_data;
        3'd2:    rx_buf_d[15:8]  = rx_data;
        default: rx_buf_d[7:0]   = rx_data;
      endcase
      rx_cnt_d = rx_cnt_q - 3'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_cls == C_BAD) begin
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            rsp_data_d  = '0;
          end else begin
            state_d  = S_SEND;
            cls_d    = req_cls;
            tx_sh_d  = {req_cmd, (req_cls == C_SET) ? req_value : 32'h0};
            tx_cnt_d = (req_cls == C_SET) ? 3'd5 : 3'd1;
            rx_cnt_d = (req_cls == C_GET) ? 3'd4 :
                       ((req_cls == C_PING) || (req_cls == C_ARMST)) ? 3'd1 : 3'd0;
            rx_buf_d = '0;
            tmo_d    = 1'b0;
            rx_en_d  = 1'b0;
          end
        end
      end
      S_SEND: begin
        if (!tx_busy) begin
          tx_start_c = 1'b1;
          tx_data_d  = tx_sh_q[39:32];
          tx_sh_d    = {tx_sh_q[31:0], 8'h00};
          tx_cnt_d   = tx_cnt_q - 3'd1;
          rx_en_d    = 1'b1;
          first_d    = 1'b1;
          state_d    = S_WAIT_TX;
        end
      end
      S_WAIT_TX: begin
        if (first_q) begin
          first_d = 1'b0;
        end else if (!tx_busy) begin
          if (tx_cnt_q != 3'd0) begin
            state_d = S_SEND;
          end else if (rx_cnt_d == 3'd0) begin
            state_d = S_DONE;
            rx_en_d = 1'b0;
          end else begin
            state_d = S_RECV;
          end
        end
      end
      S_RECV: begin
        if (rx_capture) begin
          if (rx_cnt_q == 3'd1) begin
            state_d = S_DONE;
            rx_en_d = 1'b0;
          end
        end else if (to_cnt_q == TO_LAST) begin
          state_d = S_DONE;
          rx_en_d = 1'b0;
          tmo_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        rsp_valid_d = 1'b1;
        state_d     = S_IDLE;
        case (cls_q)
          C_GET: begin
            rsp_data_d  = rx_buf_q;
            rsp_error_d = tmo_q;
          end
          C_PING: begin
            rsp_data_d  = rx_buf_q;
            rsp_error_d = tmo_q || (rx_buf_q[7:0] != 8'h42);
          end
          C_ARMST: begin
            rsp_data_d  = {31'h0, rx_buf_q[0]};
            rsp_error_d = tmo_q || (rx_buf_q[7:4] != 4'hF);
          end
          default: begin
            rsp_data_d  = '0;
            rsp_error_d = 1'b0;
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cls_q       <= C_PLAIN;
      tx_sh_q     <= '0;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      rx_buf_q    <= '0;
      to_cnt_q    <= '0;
      first_q     <= 1'b0;
      rx_en_q     <= 1'b0;
      tmo_q       <= 1'b0;
      tx_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      tx_sh_q     <= tx_sh_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_buf_q    <= rx_buf_d;
      to_cnt_q    <= to_cnt_d;
      first_q     <= first_d;
      rx_en_q     <= rx_en_d;
      tmo_q       <= tmo_d;
      tx_data_q   <= tx_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  // tx_start is combinational on tx_busy so the byte leaves on the first free cycle;
  // the mux lets tx_data change in that same cycle and then holds it.
  assign tx_start  = tx_start_c;
  assign tx_data   = tx_start_c ? tx_sh_q[39:32] : tx_data_q;
  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_glitch_cmd_master.sv
// Directed bench for glitch_cmd_master: a vector table of complete requests plus
// hand-written sequences for busy hold-off, timeout, stray bytes and mid-command reset.
module tb_glitch_cmd_master;

  localparam int unsigned TO = 50;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_cmd;
  logic [31:0] req_value;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        rx_done;
  logic [7:0]  rx_data;

  logic        mbusy;
  logic        hold_busy;
  assign tx_busy = mbusy | hold_busy;

  glitch_cmd_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_value(req_value),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .rx_done(rx_done), .rx_data(rx_data)
  );

  initial forever #5 clk = ~clk;

  int unsigned cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int unsigned checks = 0;
  int unsigned failures = 0;

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Transmitter model: logs each started byte, then stays busy for busy_len cycles.
  logic [7:0]  txq[$];
  int unsigned txc[$];
  int unsigned busy_len = 2;
  int unsigned tx_done_cnt = 0;
  int unsigned busy_fall_cyc = 0;
  int unsigned bad_start = 0;
  initial begin
    mbusy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        txq.push_back(tx_data);
        txc.push_back(cyc);
        if (tx_busy) bad_start++;
        @(posedge clk);
        #1 mbusy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 mbusy = 1'b0;
        tx_done_cnt++;
        busy_fall_cyc = cyc;
      end
    end
  end

  int unsigned rsp_cnt = 0;
  int unsigned rsp_cyc = 0;
  logic [31:0] rsp_dat = '0;
  logic        rsp_err = 1'b0;
  initial forever begin
    @(negedge clk);
    if (rsp_valid) begin
      rsp_cnt++;
      rsp_cyc = cyc;
      rsp_dat = rsp_data;
      rsp_err = rsp_error;
    end
  end

  int unsigned acc_cyc = 0;
  int unsigned last_rx_cyc = 0;

  task automatic send_req(input logic [7:0] c, input logic [31:0] v);
    for (int k = 0; k < 400 && !req_ready; k++) begin
      @(posedge clk);
      #1;
    end
    req_valid = 1'b1;
    req_cmd   = c;
    req_value = v;
    acc_cyc   = cyc;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_done     = 1'b1;
    rx_data     = b;
    last_rx_cyc = cyc;
    @(posedge clk);
    #1 rx_done = 1'b0;
  endtask

  task automatic wait_tx(input int unsigned target);
    for (int k = 0; k < 400 && tx_done_cnt < target; k++) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int unsigned prev);
    for (int k = 0; k < 300 && rsp_cnt <= prev; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct packed {
    logic [7:0]  cmd;
    logic [31:0] val;
    logic [2:0]  nrx;
    logic [31:0] rxw;
    logic [2:0]  ntx;
    logic [39:0] txw;
    logic [31:0] data;
    logic        err;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned qb, db, rb, h, c, d;
    logic [7:0] eb;

    vecs[0]  = '{cmd:8'hA0, val:32'h00001234, nrx:3'd0, rxw:32'h0,          ntx:3'd5, txw:40'hA0_00_00_12_34, data:32'h0,        err:1'b0};
    vecs[1]  = '{cmd:8'hB0, val:32'hFFFFFFFF, nrx:3'd4, rxw:32'h00_00_00_64, ntx:3'd1, txw:40'hB0_00_00_00_00, data:32'h00000064, err:1'b0};
    vecs[2]  = '{cmd:8'hC0, val:32'h0,        nrx:3'd1, rxw:32'h42_00_00_00, ntx:3'd1, txw:40'hC0_00_00_00_00, data:32'h00000042, err:1'b0};
    vecs[3]  = '{cmd:8'hC0, val:32'h0,        nrx:3'd1, rxw:32'h41_00_00_00, ntx:3'd1, txw:40'hC0_00_00_00_00, data:32'h00000041, err:1'b1};
    vecs[4]  = '{cmd:8'h03, val:32'h0,        nrx:3'd1, rxw:32'hF1_00_00_00, ntx:3'd1, txw:40'h03_00_00_00_00, data:32'h00000001, err:1'b0};
    vecs[5]  = '{cmd:8'h03, val:32'h0,        nrx:3'd1, rxw:32'h51_00_00_00, ntx:3'd1, txw:40'h03_00_00_00_00, data:32'h00000001, err:1'b1};
    vecs[6]  = '{cmd:8'h01, val:32'h12345678, nrx:3'd0, rxw:32'h0,          ntx:3'd1, txw:40'h01_00_00_00_00, data:32'h0,        err:1'b0};
    vecs[7]  = '{cmd:8'hA2, val:32'hDEADBEEF, nrx:3'd0, rxw:32'h0,          ntx:3'd5, txw:40'hA2_DE_AD_BE_EF, data:32'h0,        err:1'b0};
    vecs[8]  = '{cmd:8'hB1, val:32'h0,        nrx:3'd4, rxw:32'h12_34_56_78, ntx:3'd1, txw:40'hB1_00_00_00_00, data:32'h12345678, err:1'b0};
    vecs[9]  = '{cmd:8'h02, val:32'h0,        nrx:3'd0, rxw:32'h0,          ntx:3'd1, txw:40'h02_00_00_00_00, data:32'h0,        err:1'b0};
    vecs[10] = '{cmd:8'h04, val:32'h0,        nrx:3'd0, rxw:32'h0,          ntx:3'd1, txw:40'h04_00_00_00_00, data:32'h0,        err:1'b0};

    rst_n = 1'b0; req_valid = 1'b0; req_cmd = '0; req_value = '0;
    rx_done = 1'b0; rx_data = '0; hold_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_tx_start", tx_start, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_error", rsp_error, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      qb = txq.size(); db = tx_done_cnt; rb = rsp_cnt;
      busy_len = (vecs[i].ntx == 3'd5) ? 10 : 2;
      send_req(vecs[i].cmd, vecs[i].val);
      wait_tx(db + vecs[i].ntx);
      for (int j = 0; j < int'(vecs[i].nrx); j++) begin
        rx_byte(vecs[i].rxw[31-8*j -: 8]);
        @(posedge clk);
        #1;
      end
      wait_rsp(rb);
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("v%0d_rsp_count", i), rsp_cnt, rb + 1);
      chk($sformatf("v%0d_tx_count", i), txq.size() - qb, vecs[i].ntx);
      for (int j = 0; j < int'(vecs[i].ntx); j++) begin
        eb = vecs[i].txw[39-8*j -: 8];
        if (qb + j < txq.size()) chk($sformatf("v%0d_tx_byte%0d", i, j), txq[qb+j], eb);
      end
      if (qb < txc.size()) chk($sformatf("v%0d_first_start_lat", i), txc[qb], acc_cyc + 1);
      chk($sformatf("v%0d_rsp_data", i), rsp_dat, vecs[i].data);
      chk($sformatf("v%0d_rsp_error", i), rsp_err, vecs[i].err);
      if (vecs[i].nrx != 3'd0) chk($sformatf("v%0d_rx_to_rsp_lat", i), rsp_cyc, last_rx_cyc + 2);
      else chk($sformatf("v%0d_tx_to_rsp_lat", i), rsp_cyc, busy_fall_cyc + 2);
    end

    // Unknown command: immediate error response, nothing on the wire
    qb = txq.size(); rb = rsp_cnt;
    send_req(8'h55, 32'h0);
    wait_rsp(rb);
    repeat (3) @(posedge clk);
    #1;
    chk("bad_cmd_no_tx", txq.size(), qb);
    chk("bad_cmd_rsp_count", rsp_cnt, rb + 1);
    chk("bad_cmd_rsp_lat", rsp_cyc, acc_cyc + 1);
    chk("bad_cmd_rsp_error", rsp_err, 1'b1);
    chk("bad_cmd_rsp_data", rsp_dat, 32'h0);

    // Transmitter held busy for 100 cycles: the start must wait for it
    busy_len = 2; qb = txq.size(); rb = rsp_cnt;
    hold_busy = 1'b1;
    send_req(8'h01, 32'h0);
    repeat (100) @(posedge clk);
    #1;
    chk("busy_hold_no_start", txq.size(), qb);
    hold_busy = 1'b0;
    h = cyc;
    wait_rsp(rb);
    if (qb < txc.size()) chk("busy_release_start_cyc", txc[qb], h);
    chk("busy_release_rsp_count", rsp_cnt, rb + 1);

    // Reply stops after two bytes
    db = tx_done_cnt; rb = rsp_cnt;
    send_req(8'hB2, 32'h0);
    wait_tx(db + 1);
    rx_byte(8'hAA);
    @(posedge clk);
    #1;
    rx_byte(8'hBB);
    c = last_rx_cyc;
    wait_rsp(rb);
    chk("tmo_rsp_cyc", rsp_cyc, c + 52);
    chk("tmo_rsp_data", rsp_dat, 32'hAABB0000);
    chk("tmo_rsp_error", rsp_err, 1'b1);

    // A byte arriving on the timeout cycle restarts the wait
    repeat (3) @(posedge clk);
    #1;
    db = tx_done_cnt; rb = rsp_cnt;
    send_req(8'hB2, 32'h0);
    wait_tx(db + 1);
    rx_byte(8'hAA);
    @(posedge clk);
    #1;
    rx_byte(8'hBB);
    c = last_rx_cyc;
    while (cyc < c + 50) begin
      @(posedge clk);
      #1;
    end
    rx_byte(8'hCC);
    d = last_rx_cyc;
    wait_rsp(rb);
    chk("tmo_race_rsp_cyc", rsp_cyc, d + 52);
    chk("tmo_race_rsp_data", rsp_dat, 32'hAABBCC00);
    chk("tmo_race_rsp_error", rsp_err, 1'b1);

    // Stray reply byte while idle
    repeat (3) @(posedge clk);
    #1;
    rb = rsp_cnt;
    rx_byte(8'h99);
    repeat (5) @(posedge clk);
    #1;
    chk("stray_rx_rsp_data", rsp_data, 32'hAABBCC00);
    chk("stray_rx_no_rsp", rsp_cnt, rb);

    // Reset in the middle of a SET
    busy_len = 10; db = tx_done_cnt; rb = rsp_cnt;
    send_req(8'hA1, 32'h11223344);
    wait_tx(db + 2);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx_start", tx_start, 1'b0);
    chk("mid_rst_tx_data", tx_data, 8'h00);
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk("mid_rst_rsp_data", rsp_data, 32'h0);
    chk("mid_rst_rsp_error", rsp_error, 1'b0);
    chk("mid_rst_req_ready", req_ready, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("mid_rst_no_rsp", rsp_cnt, rb);

    // Recovery after reset: a fresh PING goes out cleanly
    busy_len = 2; qb = txq.size(); db = tx_done_cnt; rb = rsp_cnt;
    send_req(8'hC0, 32'h0);
    wait_tx(db + 1);
    rx_byte(8'h42);
    wait_rsp(rb);
    if (qb < txq.size()) chk("post_rst_tx_byte", txq[qb], 8'hC0);
    chk("post_rst_tx_count", txq.size() - qb, 1);
    chk("post_rst_rsp_data", rsp_dat, 32'h42);
    chk("post_rst_rsp_error", rsp_err, 1'b0);

    chk("tx_start_while_busy", bad_start, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
